// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// restoring DIVU, sequenced by an IDLE/EXEC/DONE FSM with registered outputs.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpSlt = 3'd5;
  localparam logic [2:0] OpMul = 3'd6;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]    cnt_q;

  // Single-cycle datapath, evaluated straight from the inputs at acceptance.
  logic [WIDTH-1:0] sum, dif, alu_res;
  logic             alu_ovf;

  always_comb begin
    sum     = in1 + in2;
    dif     = in1 - in2;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUOp)
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OpSub: begin
        alu_res = dif;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
      end
      OpAnd:   alu_res = in1 & in2;
      OpOr:    alu_res = in1 | in2;
      OpXor:   alu_res = in1 ^ in2;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      default: alu_res = '0;
    endcase
  end

  // One iteration of MUL (acc += a if b[0]) or DIVU (acc is the remainder,
  // a shifts the dividend out and the quotient in). A zero divisor always
  // "fits", so the quotient naturally comes out all ones.
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_acc, step_a, step_b, final_res;

  always_comb begin
    rem_shift = {acc_q, a_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, b_q};
    div_ge    = rem_shift >= {1'b0, b_q};
    if (op_q == OpMul) begin
      step_acc = acc_q + (b_q[0] ? a_q : '0);
      step_a   = a_q << 1;
      step_b   = b_q >> 1;
    end else begin
      step_acc = div_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      step_a   = {a_q[WIDTH-2:0], div_ge};
      step_b   = b_q;
    end
    final_res = (op_q == OpMul) ? step_acc : step_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out     <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q  <= ALUOp;
            a_q   <= in1;
            b_q   <= in2;
            acc_q <= '0;
            cnt_q <= '0;
            if (ALUOp >= OpMul) begin
              busy    <= 1'b1;
              state_q <= StExec;
            end else begin
              out     <= alu_res;
              zero    <= (alu_res == '0);
              ovf     <= alu_ovf;
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StExec: begin
          acc_q <= step_acc;
          a_q   <= step_a;
          b_q   <= step_b;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            out     <= final_res;
            zero    <= (final_res == '0);
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
